// File: rtl/mult_err_monitor_if.sv
// Result-quadruple handshake bus between the multiplier bank
// and the error monitor.
interface mult_err_monitor_if;
  logic        in_valid;
  logic        in_ready;
  logic        exception_in;
  logic [31:0] result;
  logic [31:0] result_approx;
  logic [31:0] result_drum;
  logic [31:0] result_foil;

  modport master (
    output in_valid,
    output exception_in,
    output result,
    output result_approx,
    output result_drum,
    output result_foil,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  exception_in,
    input  result,
    input  result_approx,
    input  result_drum,
    input  result_foil,
    output in_ready
  );
endinterface

// File: rtl/mult_err_monitor.sv
// On-chip ULP error statistics for approximate multipliers
// (approx, DRUM, FOIL) against the exact product.
module mult_err_monitor #(
  parameter int SAMPLES = 10000,
  parameter int ACC_W   = 48
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  mult_err_monitor_if.slave bus,
  input  logic [1:0]       sel,
  output logic [31:0]      match_cnt,
  output logic [30:0]      max_err,
  output logic [ACC_W-1:0] sum_err,
  output logic [31:0]      sample_cnt,
  output logic [31:0]      skip_cnt,
  output logic             busy,
  output logic             done
);

  localparam int SW = (ACC_W > 31 ? ACC_W : 31) + 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  state_t state, state_nx;

  logic                   ready;
  logic                   accept;
  logic                   last;
  logic                   s1_valid;
  logic                   s1_exc;
  logic [3:0][31:0]       s1_q;
  logic                   skip;
  logic [2:0][30:0]       err;
  logic [2:0][SW-1:0]     wide;
  logic [2:0][ACC_W-1:0]  sum_nx;
  logic [2:0][31:0]       match_q;
  logic [2:0][30:0]       max_q;
  logic [2:0][ACC_W-1:0]  sum_q;

  // Sign-magnitude ULP distance; opposite signs add magnitudes.
  function automatic logic [30:0] ulp_err(
    input logic [31:0] a,
    input logic [31:0] b
  );
    logic [31:0] s;
    s = {1'b0, a[30:0]} + {1'b0, b[30:0]};
    if (a[31] == b[31])
      ulp_err = (a[30:0] >= b[30:0]) ? a[30:0] - b[30:0]
                                     : b[30:0] - a[30:0];
    else
      ulp_err = s[31] ? 31'h7FFF_FFFF : s[30:0];
  endfunction

  assign bus.in_ready = ready;
  assign accept = bus.in_valid && ready && !start;
  assign last   = (sample_cnt == 32'(SAMPLES - 1));

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next state and handshake/status outputs; start wins from any state.
  always_comb begin
    state_nx = state;
    ready    = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state)
      IDLE: ;
      RUN: begin
        ready = 1'b1;
        busy  = 1'b1;
        if (accept && last) state_nx = DRAIN;
      end
      DRAIN: begin
        busy     = 1'b1;
        state_nx = DONE;
      end
      DONE: done = 1'b1;
      default: state_nx = IDLE;
    endcase
    if (start) state_nx = RUN;
  end

  // Stage 1: capture the accepted quadruple.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_exc   <= 1'b0;
      s1_q     <= '0;
    end else if (start) begin
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_exc  <= bus.exception_in;
        s1_q[0] <= bus.result;
        s1_q[1] <= bus.result_approx;
        s1_q[2] <= bus.result_drum;
        s1_q[3] <= bus.result_foil;
      end
    end
  end

  // Accepted-sample counter, bumped on the accept edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       sample_cnt <= '0;
    else if (start)  sample_cnt <= '0;
    else if (accept) sample_cnt <= sample_cnt + 32'd1;
  end

  assign skip = s1_exc || (&s1_q[0][30:23]);

  // Stage 2 arithmetic: per-design error and saturating sum.
  always_comb begin
    err    = '0;
    wide   = '0;
    sum_nx = '0;
    for (int d = 0; d < 3; d++) begin
      err[d]    = ulp_err(s1_q[0], s1_q[d+1]);
      wide[d]   = SW'(sum_q[d]) + SW'(err[d]);
      sum_nx[d] = (|(wide[d] >> ACC_W)) ? '1
                                        : wide[d][ACC_W-1:0];
    end
  end

  // Stage 2 statistics update.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      skip_cnt <= '0;
      match_q  <= '0;
      max_q    <= '0;
      sum_q    <= '0;
    end else if (start) begin
      skip_cnt <= '0;
      match_q  <= '0;
      max_q    <= '0;
      sum_q    <= '0;
    end else if (s1_valid) begin
      if (skip) begin
        skip_cnt <= skip_cnt + 32'd1;
      end else begin
        for (int d = 0; d < 3; d++) begin
          if (err[d] == '0) match_q[d] <= match_q[d] + 32'd1;
          if (err[d] > max_q[d]) max_q[d] <= err[d];
          sum_q[d] <= sum_nx[d];
        end
      end
    end
  end

  // Readback mux; select 3 reads zeros.
  always_comb begin
    match_cnt = '0;
    max_err   = '0;
    sum_err   = '0;
    unique case (sel)
      2'd0: begin
        match_cnt = match_q[0];
        max_err   = max_q[0];
        sum_err   = sum_q[0];
      end
      2'd1: begin
        match_cnt = match_q[1];
        max_err   = max_q[1];
        sum_err   = sum_q[1];
      end
      2'd2: begin
        match_cnt = match_q[2];
        max_err   = max_q[2];
        sum_err   = sum_q[2];
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mult_err_monitor.sv
// Directed bench for mult_err_monitor: a SAMPLES=4 instance
// plus a SAMPLES=2, ACC_W=8 instance for sum saturation.
module tb_mult_err_monitor;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start_a = 1'b0;
  logic        start_b = 1'b0;
  logic        valid = 1'b0;
  logic        exc = 1'b0;
  logic [31:0] r = '0, ra = '0, rd = '0, rf = '0;
  logic [1:0]  sel = 2'd0;

  logic [31:0] a_match, a_scnt, a_skip;
  logic [30:0] a_max;
  logic [47:0] a_sum;
  logic        a_busy, a_done;
  logic [31:0] b_match, b_scnt, b_skip;
  logic [30:0] b_max;
  logic [7:0]  b_sum;
  logic        b_busy, b_done;

  int total = 0;
  int bad = 0;

  mult_err_monitor_if bus_a ();
  mult_err_monitor_if bus_b ();

  assign bus_a.in_valid      = valid;
  assign bus_a.exception_in  = exc;
  assign bus_a.result        = r;
  assign bus_a.result_approx = ra;
  assign bus_a.result_drum   = rd;
  assign bus_a.result_foil   = rf;
  assign bus_b.in_valid      = valid;
  assign bus_b.exception_in  = exc;
  assign bus_b.result        = r;
  assign bus_b.result_approx = ra;
  assign bus_b.result_drum   = rd;
  assign bus_b.result_foil   = rf;

  mult_err_monitor #(.SAMPLES(4), .ACC_W(48)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .bus(bus_a),
    .sel(sel), .match_cnt(a_match), .max_err(a_max),
    .sum_err(a_sum), .sample_cnt(a_scnt), .skip_cnt(a_skip),
    .busy(a_busy), .done(a_done)
  );

  mult_err_monitor #(.SAMPLES(2), .ACC_W(8)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .bus(bus_b),
    .sel(sel), .match_cnt(b_match), .max_err(b_max),
    .sum_err(b_sum), .sample_cnt(b_scnt), .skip_cnt(b_skip),
    .busy(b_busy), .done(b_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        exc;
    logic [31:0] r, ra, rd, rf;
    logic        skip;
    logic [30:0] e [3];
  } vec_t;

  vec_t tab [4];
  logic [63:0] em [3];
  logic [63:0] ex [3];
  logic [63:0] es [3];
  int sk;
  int acc;
  logic pat [7];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_stats_a(input string tag);
    for (int d = 0; d < 3; d++) begin
      sel = 2'(d);
      #1;
      chk($sformatf("%s_match%0d", tag, d), 64'(a_match), em[d]);
      chk($sformatf("%s_max%0d", tag, d), 64'(a_max), ex[d]);
      chk($sformatf("%s_sum%0d", tag, d), 64'(a_sum), es[d]);
    end
    sel = 2'd0;
  endtask

  task automatic set_exp(input int d, input logic [63:0] m,
                         input logic [63:0] x, input logic [63:0] s);
    em[d] = m;
    ex[d] = x;
    es[d] = s;
  endtask

  task automatic drive(input logic e, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] c,
                       input logic [31:0] f);
    exc = e;
    r   = a;
    ra  = b;
    rd  = c;
    rf  = f;
  endtask

  initial begin
    tab[0] = '{1'b0, 32'h3F800000, 32'h3F800000, 32'h3F800000,
               32'h3F800000, 1'b0, '{31'd0, 31'd0, 31'd0}};
    tab[1] = '{1'b0, 32'h40000000, 32'h40000003, 32'hC0000000,
               32'h3FFFFFFF, 1'b0, '{31'd3, 31'h7FFFFFFF, 31'd1}};
    tab[2] = '{1'b1, 32'h40400000, 32'h12345678, 32'hC0400000,
               32'h40400001, 1'b1, '{31'd0, 31'd0, 31'd0}};
    tab[3] = '{1'b0, 32'h7F800000, 32'h7F800001, 32'h00000000,
               32'hFF800000, 1'b1, '{31'd0, 31'd0, 31'd0}};
    pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

    // Reset state.
    tick;
    tick;
    chk("rst_ready", 64'(bus_a.in_ready), 64'd0);
    chk("rst_busy", 64'(a_busy), 64'd0);
    chk("rst_done", 64'(a_done), 64'd0);
    chk("rst_scnt", 64'(a_scnt), 64'd0);
    chk("rst_skip", 64'(a_skip), 64'd0);
    for (int d = 0; d < 3; d++) set_exp(d, 0, 0, 0);
    chk_stats_a("rst");
    reset = 1'b0;
    tick;

    // Run A: table of mixed samples with skips.
    start_a = 1'b1;
    tick;
    start_a = 1'b0;
    chk("a_ready", 64'(bus_a.in_ready), 64'd1);
    sk = 0;
    for (int i = 0; i < 4; i++) begin
      drive(tab[i].exc, tab[i].r, tab[i].ra, tab[i].rd, tab[i].rf);
      valid = 1'b1;
      tick;
      valid = 1'b0;
      if (i == 3) begin
        chk("a_drain_ready", 64'(bus_a.in_ready), 64'd0);
        chk("a_drain_busy", 64'(a_busy), 64'd1);
        chk("a_drain_done", 64'(a_done), 64'd0);
      end
      tick;
      if (tab[i].skip) begin
        sk++;
      end else begin
        for (int d = 0; d < 3; d++) begin
          if (tab[i].e[d] == 0) em[d] = em[d] + 1;
          if (64'(tab[i].e[d]) > ex[d]) ex[d] = 64'(tab[i].e[d]);
          es[d] = es[d] + 64'(tab[i].e[d]);
        end
      end
      chk($sformatf("a_scnt%0d", i), 64'(a_scnt), 64'(i + 1));
      chk($sformatf("a_skip%0d", i), 64'(a_skip), 64'(sk));
      chk_stats_a($sformatf("a%0d", i));
    end
    chk("a_done", 64'(a_done), 64'd1);
    chk("a_idle_busy", 64'(a_busy), 64'd0);
    sel = 2'd3;
    #1;
    chk("a_sel3_match", 64'(a_match), 64'd0);
    chk("a_sel3_max", 64'(a_max), 64'd0);
    chk("a_sel3_sum", 64'(a_sum), 64'd0);
    sel = 2'd0;

    // Run B: start with valid high is not an accept; then streaming.
    drive(1'b0, 32'h3F800000, 32'h3F800000, 32'h3F800000,
          32'h3F800000);
    valid = 1'b1;
    start_a = 1'b1;
    tick;
    start_a = 1'b0;
    chk("b_start_noacc", 64'(a_scnt), 64'd0);
    chk("b_start_clr", 64'(a_skip), 64'd0);
    acc = 0;
    for (int c = 0; c < 20 && acc < 4; c++) begin
      if (bus_a.in_ready && valid) acc++;
      tick;
    end
    chk("b_accepts", 64'(acc), 64'd4);
    chk("b_notdone", 64'(a_done), 64'd0);
    tick;
    valid = 1'b0;
    chk("b_done", 64'(a_done), 64'd1);
    chk("b_scnt", 64'(a_scnt), 64'd4);
    chk("b_skip", 64'(a_skip), 64'd0);
    for (int d = 0; d < 3; d++) set_exp(d, 4, 0, 0);
    chk_stats_a("b");

    // Run C: toggling valid; accepts only while ready.
    drive(1'b0, 32'h3F800000, 32'h3F800005, 32'h3F800000,
          32'hBF800000);
    start_a = 1'b1;
    tick;
    start_a = 1'b0;
    acc = 0;
    for (int c = 0; c < 7; c++) begin
      valid = pat[c];
      if (c == 5) begin
        chk("c_drain_ready", 64'(bus_a.in_ready), 64'd0);
        chk("c_drain_busy", 64'(a_busy), 64'd1);
      end
      if (bus_a.in_ready && valid) acc++;
      tick;
    end
    valid = 1'b0;
    chk("c_accepts", 64'(acc), 64'd4);
    chk("c_scnt", 64'(a_scnt), 64'd4);
    chk("c_done", 64'(a_done), 64'd1);
    set_exp(0, 0, 5, 20);
    set_exp(1, 4, 0, 0);
    set_exp(2, 0, 64'h7F000000, 64'h1FC000000);
    chk_stats_a("c");

    // Run D: reset in the middle of a run.
    start_a = 1'b1;
    tick;
    start_a = 1'b0;
    valid = 1'b1;
    tick;
    tick;
    valid = 1'b0;
    tick;
    chk("d_pre_scnt", 64'(a_scnt), 64'd2);
    chk("d_pre_sum", 64'(a_sum), 64'd10);
    reset = 1'b1;
    #1;
    chk("d_rst_scnt", 64'(a_scnt), 64'd0);
    chk("d_rst_busy", 64'(a_busy), 64'd0);
    chk("d_rst_ready", 64'(bus_a.in_ready), 64'd0);
    for (int d = 0; d < 3; d++) set_exp(d, 0, 0, 0);
    chk_stats_a("d_rst");
    tick;
    reset = 1'b0;
    tick;
    chk("d_idle_busy", 64'(a_busy), 64'd0);
    chk("d_idle_done", 64'(a_done), 64'd0);
    start_a = 1'b1;
    tick;
    start_a = 1'b0;
    valid = 1'b1;
    acc = 0;
    for (int c = 0; c < 20 && acc < 4; c++) begin
      if (bus_a.in_ready && valid) acc++;
      tick;
    end
    valid = 1'b0;
    tick;
    chk("d_accepts", 64'(acc), 64'd4);
    chk("d_scnt", 64'(a_scnt), 64'd4);
    chk("d_done", 64'(a_done), 64'd1);

    // Small instance: 8-bit sums saturate rather than wrap.
    drive(1'b0, 32'h3F800000, 32'h3F8000C8, 32'h3F8000C8,
          32'h3F800000);
    start_b = 1'b1;
    tick;
    start_b = 1'b0;
    valid = 1'b1;
    acc = 0;
    for (int c = 0; c < 20 && acc < 2; c++) begin
      if (bus_b.in_ready && valid) acc++;
      tick;
    end
    valid = 1'b0;
    tick;
    chk("s_accepts", 64'(acc), 64'd2);
    chk("s_done", 64'(b_done), 64'd1);
    sel = 2'd0;
    #1;
    chk("s_sum0", 64'(b_sum), 64'hFF);
    chk("s_max0", 64'(b_max), 64'd200);
    chk("s_match0", 64'(b_match), 64'd0);
    sel = 2'd1;
    #1;
    chk("s_sum1", 64'(b_sum), 64'hFF);
    sel = 2'd2;
    #1;
    chk("s_sum2", 64'(b_sum), 64'd0);
    chk("s_match2", 64'(b_match), 64'd2);
    chk("s_scnt", 64'(b_scnt), 64'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mult_err_monitor.md
# mult_err_monitor

Synthesizable response-side collector for the multiplier bank (exact, approximate, DRUM, FOIL). It accepts one result quadruple per handshake and measures the ULP distance of each approximate result from the exact result. Over a programmed run of samples it accumulates per-design statistics: exact-match count, maximum error and saturating error sum. These are read back through a select port, so the error characterisation that is otherwise done offline from dumped result files runs on-chip.

## Interface
Parameters:
- SAMPLES, 10000, number of accepted samples per run (≥1)
- ACC_W, 48, width of each error-sum accumulator

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- start  in  1  one-cycle pulse; clears statistics and begins a run
- in_valid  in  1  result quadruple valid
- in_ready  out  1  monitor can accept (high only in RUN)
- exception_in  in  1  exact multiplier Exception flag for this sample
- result  in  32  exact IEEE-754 single product
- result_approx  in  32  approximate product
- result_drum  in  32  DRUM product
- result_foil  in  32  FOIL product
- sel  in  2  statistic read select: 0 approx, 1 drum, 2 foil, 3 reads zeros
- match_cnt  out  32  samples with error 0 for the selected design
- max_err  out  31  maximum error for the selected design
- sum_err  out  ACC_W  saturating error sum for the selected design
- sample_cnt  out  32  samples accepted this run, skipped ones included
- skip_cnt  out  32  samples excluded from statistics
- busy  out  1  high in RUN and DRAIN
- done  out  1  high in DONE

## Operation
- FSM states and transitions:
  - IDLE: waits for start, then goes to RUN.
  - RUN: in_ready=1. A sample is accepted on an edge where in_valid && in_ready. When the accept that makes sample_cnt reach SAMPLES occurs, go to DRAIN.
  - DRAIN: one cycle, then DONE.
  - DONE: done=1. start goes to RUN.
- start in any state clears all accumulators, sample_cnt, skip_cnt and the pipeline valid bit, then enters RUN. If start coincides with in_valid, that sample is not accepted.
- Pipeline:
  - Stage 1 registers the accepted quadruple and exception_in, plus a valid bit.
  - Stage 2 computes the errors and updates the accumulators.
  - sample_cnt increments at the accept edge.
- Skip rule: a sample is skipped when exception_in=1 or result[30:23]==8'hFF. It increments skip_cnt in stage 2 and does not touch the per-design statistics.
- Error metric, per design x, using a 31-bit magnitude m=r[30:0]:
  - Signs equal: err = |m_exact − m_x|.
  - Signs differ: err = m_exact + m_x, saturated to 31'h7FFF_FFFF.
- Per design, when not skipped:
  - err==0: match_cnt += 1.
  - max_err = max(max_err, err).
  - sum_err += err, saturating at all ones; no wrap.
- Readback outputs are combinational muxes of the registered statistics by sel.
- Statistics hold their values in DONE and IDLE until the next start.

## Timing
- Reset values: state IDLE, in_ready 0, busy 0, done 0, and all counters and accumulators 0.
- Reset mid-run aborts immediately. No partial statistics survive.
- Latency: a sample accepted at edge k is reflected in match_cnt, max_err, sum_err and skip_cnt after edge k+1.
- The last sample is accepted at edge k, giving DRAIN in cycle k..k+1. DONE is entered at edge k+1 with final statistics valid in the same cycle done rises.
- Throughput is one sample per cycle while in_valid stays high.
- in_ready drops in the cycle after the final accept. Producers must hold data while in_ready=0.

## Test plan
- Reset, then start, then 4 identical quadruples (all 32'h3F800000) -> done after the 4th accept +1 edge; all designs show match_cnt=4, max_err=0, sum_err=0; sample_cnt=4, skip_cnt=0 (SAMPLES=4).
- result=32'h40000000 and approx=32'h40000003 -> approx max_err=3, sum_err=3. With drum=32'hC0000000: drum err=31'h80000000 saturated to 31'h7FFF_FFFF.
- Sample with exception_in=1, then a sample with result=32'h7F800000 -> skip_cnt=2, per-design statistics unchanged, sample_cnt=2.
- in_valid toggling 1,0,1,1 with SAMPLES=3 -> exactly 3 accepts; in_ready=0 after the final accept; busy high through DRAIN.
- ACC_W=8 and 2 samples of error 200 -> sum_err=8'hFF (saturated, not 8'h90).
- Reset asserted mid-run after 2 of 4 samples -> all outputs 0 and state IDLE. A later start and 4 samples give sample_cnt=4.
